// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core: one round per clock on a shared round datapath.
// AES-128/192/256 selected by the (NK, NR) parameter pair.
module aes_cipher_iter #(
    parameter int unsigned NK = 4,
    parameter int unsigned NR = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [32*NK-1:0]  i_key,
    input  logic [127:0]      i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [127:0]      o_data,
    output logic              o_busy
);

    localparam int unsigned KW = 32 * NK;
    localparam int unsigned NW = 4 * (NR + 1);
    localparam int unsigned CW = $clog2(NR + 1);

    if (!((NK == 4 && NR == 10) || (NK == 6 && NR == 12) || (NK == 8 && NR == 14))) begin : g_bad_param
        $error("aes_cipher_iter: illegal (NK, NR) pair");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // GF(2^8) helpers; the S-box is the field inverse (x^254) followed by the affine map
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gf_mul(inv, inv);
            if (i != 0) inv = gf_mul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] rk);
        return s ^ rk;
    endfunction

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [127:0]   data_q, data_d;
    logic [KW-1:0]  key_q, key_d;
    logic           valid_q, valid_d;
    logic [127:0]   out_q, out_d;

    logic [31:0]    ek_w [NW];
    logic [127:0]   round_key;
    logic [127:0]   round_sr;
    logic [127:0]   round_mc;
    logic [127:0]   round_res;
    logic           accept;

    // Full key schedule from the latched key; stable for the whole block
    always_comb begin : key_expand
        logic [31:0] wl [NW];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        t  = '0;
        for (int i = 0; i < int'(NK); i++) begin
            wl[i] = key_q[KW-1-32*i -: 32];
        end
        for (int i = int'(NK); i < int'(NW); i++) begin
            t = wl[i-1];
            if (i % int'(NK) == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end else if (NK > 6 && (i % int'(NK) == 4)) begin
                t = sub_word(t);
            end
            wl[i] = wl[i-int'(NK)] ^ t;
        end
        ek_w = wl;
    end

    always_comb begin
        round_key = '0;
        for (int r = 0; r <= int'(NR); r++) begin
            if (cnt_q == CW'(r)) round_key = {ek_w[4*r], ek_w[4*r+1], ek_w[4*r+2], ek_w[4*r+3]};
        end
    end

    // Final round (counter == NR) skips mix_columns
    assign round_sr  = shift_rows(sub_bytes(data_q));
    assign round_mc  = (cnt_q == CW'(NR)) ? round_sr : mix_columns(round_sr);
    assign round_res = add_round_key(round_mc, round_key);

    assign o_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & i_ready);
    assign accept  = i_valid & o_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            key_q   <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        key_d   = key_q;
        valid_d = valid_q;
        out_d   = out_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    key_d   = i_key;
                    data_d  = i_data ^ i_key[KW-1 -: 128];
                    cnt_d   = CW'(1);
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (cnt_q == CW'(NR)) begin
                    out_d   = round_res;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    data_d = round_res;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    if (i_valid) begin
                        key_d   = i_key;
                        data_d  = i_data ^ i_key[KW-1 -: 128];
                        cnt_d   = CW'(1);
                        state_d = S_ROUND;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_valid = valid_q;
    assign o_data  = out_q;
    assign o_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: FIPS-197 vectors, handshake timing and random traffic
// against a byte-level AES model and a one-block occupancy model of the core.
module tb_aes_cipher_iter;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic v4, r4, ir4, ov4, busy4;
    logic [127:0] k4, d4, od4;
    logic v6, r6, ir6, ov6, busy6;
    logic [191:0] k6;
    logic [127:0] d6, od6;
    logic v8, r8, ir8, ov8, busy8;
    logic [255:0] k8;
    logic [127:0] d8, od8;

    aes_cipher_iter #(.NK(4), .NR(10)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_valid(v4), .o_ready(r4), .i_key(k4), .i_data(d4),
        .o_valid(ov4), .i_ready(ir4), .o_data(od4), .o_busy(busy4));
    aes_cipher_iter #(.NK(6), .NR(12)) u_dut6 (
        .i_clk(clk), .i_rst(rst), .i_valid(v6), .o_ready(r6), .i_key(k6), .i_data(d6),
        .o_valid(ov6), .i_ready(ir6), .o_data(od6), .o_busy(busy6));
    aes_cipher_iter #(.NK(8), .NR(14)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(r8), .i_key(k8), .i_data(d8),
        .o_valid(ov8), .i_ready(ir8), .o_data(od8), .o_busy(busy8));

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [191:0] K6 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] C6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0] K8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C8 = 128'h8ea2b7ca516745bfeafc49904b496089;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- byte-level AES reference ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, t, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            t = inv;
            s = inv;
            for (int k = 0; k < 4; k++) begin
                t = {t[6:0], t[7]};
                s = s ^ t;
            end
            sbox_t[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input int nk, input logic [255:0] key, input logic [127:0] pt);
        logic [7:0] w [240];
        logic [7:0] s [16];
        logic [7:0] ns [16];
        logic [7:0] t [4];
        logic [7:0] tmp, rc, a0, a1, a2, a3;
        logic [127:0] res;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4*nk; i++) w[i] = key[32*nk-1-8*i -: 8];
        for (int i = nk; i < 4*(nr+1); i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[4*(i-1)+j];
            if (i % nk == 0) begin
                tmp  = t[0];
                t[0] = sbox_t[t[1]] ^ rc;
                t[1] = sbox_t[t[2]];
                t[2] = sbox_t[t[3]];
                t[3] = sbox_t[tmp];
                rc   = gm(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                for (int j = 0; j < 4; j++) t[j] = sbox_t[t[j]];
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-nk)+j] ^ t[j];
        end
        for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j];
        for (int r = 1; r <= nr; r++) begin
            for (int j = 0; j < 16; j++) ns[j] = sbox_t[s[4*(((j/4)+(j%4))%4) + (j%4)]];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = ns[4*c]; a1 = ns[4*c+1]; a2 = ns[4*c+2]; a3 = ns[4*c+3];
                    s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end
            end else begin
                for (int j = 0; j < 16; j++) s[j] = ns[j];
            end
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[16*r+j];
        end
        res = '0;
        for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- occupancy model for the NK=4 instance ----------------
    int           s_idx = 0;
    int           m_ready_at = 0;
    int           n_out = 0;
    logic         m_has = 1'b0;
    logic [127:0] m_exp = '0;
    logic         last_acc = 1'b0;
    logic         seen_ov = 1'b0;
    logic [127:0] seen_od = '0;

    // One clock: inputs were driven after the previous edge; sample at negedge, advance model.
    task automatic cycle4();
        logic exp_ov, exp_rdy;
        @(negedge clk);
        s_idx++;
        exp_ov  = m_has && (s_idx >= m_ready_at);
        exp_rdy = !m_has || (exp_ov && ir4);
        check("o_valid", 128'(ov4), 128'(exp_ov));
        check("o_ready", 128'(r4), 128'(exp_rdy));
        check("o_busy", 128'(busy4), 128'(m_has));
        if (exp_ov) check("o_data", od4, m_exp);
        seen_ov  = ov4;
        seen_od  = od4;
        last_acc = v4 && exp_rdy;
        if (exp_ov && ir4) begin
            m_has = 1'b0;
            n_out++;
        end
        if (last_acc) begin
            m_has      = 1'b1;
            m_exp      = aes_ref(4, {128'h0, k4}, d4);
            m_ready_at = s_idx + 11;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        v4 = 1'b0; v6 = 1'b0; v8 = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        m_has    = 1'b0;
        last_acc = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, 128'(ov4), 128'(0));
        check({tag, "_data"}, od4, 128'h0);
        check({tag, "_ready"}, 128'(r4), 128'(1));
        check({tag, "_busy"}, 128'(busy4), 128'(0));
        @(posedge clk);
        #1;
    endtask

    // Single block with inputs scrambled after the accept edge.
    task automatic run_vec4(input string tag, input logic [127:0] key, input logic [127:0] pt,
                            input logic [127:0] ct);
        int lat;
        v4 = 1'b1; k4 = key; d4 = pt; ir4 = 1'b1;
        cycle4();
        v4 = 1'b0;
        lat = 0;
        seen_ov = 1'b0;
        while (!seen_ov && lat < 40) begin
            k4 = rnd128();
            d4 = rnd128();
            cycle4();
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(11));
        check({tag, "_data"}, seen_od, ct);
        cycle4();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, out_k, idx, n0;
        logic [127:0] bk [3];
        logic [127:0] bp [3];

        rst = 1'b1;
        v4 = 1'b0; k4 = '0; d4 = '0; ir4 = 1'b1;
        v6 = 1'b0; k6 = '0; d6 = '0; ir6 = 1'b1;
        v8 = 1'b0; k8 = '0; d8 = '0; ir8 = 1'b1;
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");

        // FIPS-197 AES-128 vector with scrambled inputs after accept
        run_vec4("fips128", K1, P1, C1);

        // AES-192
        v6 = 1'b1; k6 = K6; d6 = P1;
        @(negedge clk);
        check("nk6_ready", 128'(r6), 128'(1));
        @(posedge clk);
        #1;
        v6 = 1'b0; k6 = {rnd128(), 64'(rnd128())}; d6 = rnd128();
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (ov6) break;
        end
        check("nk6_latency", 128'(lat), 128'(13));
        check("nk6_data", od6, C6);
        check("nk6_model", od6, aes_ref(6, {64'h0, K6}, P1));
        @(posedge clk);
        #1;

        // AES-256
        v8 = 1'b1; k8 = K8; d8 = P1;
        @(negedge clk);
        check("nk8_ready", 128'(r8), 128'(1));
        @(posedge clk);
        #1;
        v8 = 1'b0; k8 = {rnd128(), rnd128()}; d8 = rnd128();
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (ov8) break;
        end
        check("nk8_latency", 128'(lat), 128'(15));
        check("nk8_data", od8, C8);
        check("nk8_model", od8, aes_ref(8, K8, P1));
        @(posedge clk);
        #1;

        // Backpressure with a pending block held by the source
        v4 = 1'b1; k4 = KB; d4 = PB; ir4 = 1'b0;
        cycle4();
        k4 = rnd128(); d4 = rnd128();
        lat = 0;
        seen_ov = 1'b0;
        while (!seen_ov && lat < 40) begin
            cycle4();
            lat++;
        end
        check("bp_latency", 128'(lat), 128'(11));
        check("bp_data", seen_od, CB);
        repeat (5) cycle4();
        ir4 = 1'b1;
        cycle4();
        v4 = 1'b0;
        lat = 0;
        seen_ov = 1'b0;
        while (!seen_ov && lat < 40) begin
            cycle4();
            lat++;
        end
        check("bp_second_latency", 128'(lat), 128'(11));
        cycle4();

        // Back-to-back with i_valid and i_ready held high
        bk[0] = K1; bp[0] = P1;
        bk[1] = KB; bp[1] = PB;
        bk[2] = rnd128(); bp[2] = rnd128();
        n0 = n_out;
        out_k = 0;
        idx = 0;
        v4 = 1'b1; ir4 = 1'b1; k4 = bk[0]; d4 = bp[0];
        for (int c = 0; c < 60 && n_out < n0 + 3; c++) begin
            cycle4();
            if (seen_ov) begin
                out_k++;
                if (out_k == 1) check("b2b_first", seen_od, C1);
                if (out_k == 2) check("b2b_second", seen_od, CB);
            end
            if (last_acc) begin
                idx++;
                if (idx < 3) begin
                    k4 = bk[idx];
                    d4 = bp[idx];
                end else begin
                    v4 = 1'b0;
                end
            end
        end
        check("b2b_count", 128'(out_k), 128'(3));
        cycle4();

        // Reset in the middle of a block, then a fresh block
        v4 = 1'b1; k4 = K1; d4 = P1; ir4 = 1'b1;
        cycle4();
        v4 = 1'b0;
        repeat (4) cycle4();
        do_reset("midreset");
        cycle4();
        run_vec4("after_reset", K1, P1, C1);

        // Random traffic: random valid gaps, random backpressure, scrambled idle inputs
        n0 = n_out;
        last_acc = 1'b0;
        v4 = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!v4 || last_acc) begin
                v4 = ($urandom_range(0, 2) != 0);
                k4 = rnd128();
                d4 = rnd128();
            end
            ir4 = ($urandom_range(0, 3) != 0);
            cycle4();
        end
        v4 = 1'b0;
        ir4 = 1'b1;
        repeat (15) cycle4();
        check("rand_progress", 128'(n_out - n0 >= 20), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
